scpad_dram_responder: RTL and testbench

//   DRAM-side responder for one scratchpad backend's DRAM port. It accepts
//   be_dram_req packets (reads and masked writes), queues them in order, and

---
 rtl/scpad_dram_responder.sv | 165 ++++++++++++++++
 tb/tb_scpad_dram_responder.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/scpad_dram_responder.sv
// DRAM-side endpoint for a scratchpad backend: in-order request FIFO,
// element-addressed backing store, fixed-latency read responses.
module scpad_dram_responder #(
  parameter int DRAM_ADDR_WIDTH = 32,
  parameter int ELEM_W          = 16,
  parameter int ID_W            = 8,
  parameter int REQ_DEPTH       = 4,
  parameter int MEM_ELEMS       = 4096,
  parameter int READ_LAT        = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       be_dram_req_valid,
  input  logic                       be_dram_req_write,
  input  logic [ID_W-1:0]            be_dram_req_id,
  input  logic [DRAM_ADDR_WIDTH-1:0] be_dram_req_dram_addr,
  input  logic [3:0]                 be_dram_req_vector_mask,
  input  logic [4*ELEM_W-1:0]        be_dram_req_wdata,
  input  logic                       be_dram_stall,
  output logic                       dram_be_stall,
  output logic                       dram_be_res_valid,
  output logic [ID_W-1:0]            dram_be_res_id,
  output logic [4*ELEM_W-1:0]        dram_be_res_rdata,
  output logic                       busy
);

  localparam int AW = $clog2(MEM_ELEMS);
  localparam int PW = $clog2(REQ_DEPTH);
  localparam int CW = (READ_LAT > 1) ? $clog2(READ_LAT) : 1;

  typedef struct packed {
    logic                write;
    logic [ID_W-1:0]     id;
    logic [AW-1:0]       addr;
    logic [3:0]          mask;
    logic [4*ELEM_W-1:0] wdata;
  } req_t;

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  req_t             fifo [REQ_DEPTH];
  req_t             incoming;
  req_t             head;
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic [PW:0]      count;
  logic             push;
  logic             pop;
  logic             load;
  state_t           state;
  state_t           state_n;
  logic [CW-1:0]    cnt;
  logic [CW-1:0]    cnt_n;
  logic [ELEM_W-1:0] mem [MEM_ELEMS];
  logic [4*ELEM_W-1:0] rd_lanes;
  logic             unused_addr;

  // Only the low address bits select an element; the rest wrap away.
  assign unused_addr = ^be_dram_req_dram_addr[DRAM_ADDR_WIDTH-1:AW];

  assign incoming = '{
    write: be_dram_req_write,
    id:    be_dram_req_id,
    addr:  be_dram_req_dram_addr[AW-1:0],
    mask:  be_dram_req_vector_mask,
    wdata: be_dram_req_wdata
  };

  assign dram_be_stall = (count == (PW+1)'(REQ_DEPTH));
  assign push          = be_dram_req_valid && !dram_be_stall;
  assign head          = fifo[rd_ptr];

  always_ff @(posedge clk) begin
    if (push) fifo[wr_ptr] <= incoming;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      unique case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    pop     = 1'b0;
    load    = 1'b0;
    unique case (state)
      IDLE: begin
        if (count != '0) begin
          pop = 1'b1;
          if (!head.write) begin
            load = 1'b1;
            if (READ_LAT == 1) begin
              state_n = RESP;
            end else begin
              state_n = WAIT;
              cnt_n   = CW'(READ_LAT - 1);
            end
          end
        end
      end
      WAIT: begin
        cnt_n = cnt - 1'b1;
        if (cnt == CW'(1)) state_n = RESP;
      end
      RESP: begin
        if (!be_dram_stall) state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst && pop && head.write) begin
      for (int k = 0; k < 4; k++) begin
        if (head.mask[k])
          mem[head.addr + AW'(k)] <= head.wdata[k*ELEM_W +: ELEM_W];
      end
    end
  end

  always_comb begin
    rd_lanes = '0;
    for (int k = 0; k < 4; k++) begin
      if (head.mask[k])
        rd_lanes[k*ELEM_W +: ELEM_W] = mem[head.addr + AW'(k)];
    end
  end

  // Response payload is captured at pop and held through RESP.
  always_ff @(posedge clk) begin
    if (rst) begin
      dram_be_res_id    <= '0;
      dram_be_res_rdata <= '0;
    end else if (load) begin
      dram_be_res_id    <= head.id;
      dram_be_res_rdata <= rd_lanes;
    end
  end

  assign dram_be_res_valid = (state == RESP);
  assign busy = (count != '0) || (state != IDLE);

endmodule

// File: tb/tb_scpad_dram_responder.sv
// Directed and randomized bench for scpad_dram_responder with an
// in-order transaction-level memory model.
module tb_scpad_dram_responder;

  localparam int DAW = 32;
  localparam int EW  = 16;
  localparam int IW  = 8;
  localparam int DEP = 4;
  localparam int ME  = 4096;
  localparam int RL  = 4;

  logic            clk;
  logic            rst;
  logic            req_valid;
  logic            req_write;
  logic [IW-1:0]   req_id;
  logic [DAW-1:0]  req_addr;
  logic [3:0]      req_mask;
  logic [4*EW-1:0] req_wdata;
  logic            be_stall;
  logic            dram_stall;
  logic            res_valid;
  logic [IW-1:0]   res_id;
  logic [4*EW-1:0] res_rdata;
  logic            busy;

  scpad_dram_responder #(
    .DRAM_ADDR_WIDTH(DAW), .ELEM_W(EW), .ID_W(IW),
    .REQ_DEPTH(DEP), .MEM_ELEMS(ME), .READ_LAT(RL)
  ) dut (
    .clk(clk),
    .rst(rst),
    .be_dram_req_valid(req_valid),
    .be_dram_req_write(req_write),
    .be_dram_req_id(req_id),
    .be_dram_req_dram_addr(req_addr),
    .be_dram_req_vector_mask(req_mask),
    .be_dram_req_wdata(req_wdata),
    .be_dram_stall(be_stall),
    .dram_be_stall(dram_stall),
    .dram_be_res_valid(res_valid),
    .dram_be_res_id(res_id),
    .dram_be_res_rdata(res_rdata),
    .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int              checks = 0;
  int              errors = 0;
  int              n_resp = 0;
  logic [EW-1:0]   mmem [ME];
  logic [IW-1:0]   expq_id [$];
  logic [4*EW-1:0] expq_data [$];
  logic [IW-1:0]   last_id;
  logic [4*EW-1:0] last_rdata;

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Response monitor: every valid cycle must show the oldest pending read.
  always @(negedge clk) begin
    if (!rst && res_valid) begin
      if (expq_id.size() == 0) begin
        chk("unexpected_res", 64'(expq_id.size()), 64'd1);
      end else begin
        chk("res_id", 64'(res_id), 64'(expq_id[0]));
        chk("res_rdata", res_rdata, expq_data[0]);
        if (!be_stall) begin
          last_id    = expq_id.pop_front();
          last_rdata = expq_data.pop_front();
          n_resp++;
        end
      end
    end
  end

  task automatic model_accept(input logic w, input logic [IW-1:0] id,
                              input logic [DAW-1:0] addr,
                              input logic [3:0] m,
                              input logic [4*EW-1:0] wd);
    int base;
    logic [4*EW-1:0] d;
    base = int'(addr % DAW'(ME));
    d = '0;
    for (int k = 0; k < 4; k++) begin
      if (m[k]) begin
        if (w) mmem[(base + k) % ME] = wd[k*EW +: EW];
        else   d[k*EW +: EW] = mmem[(base + k) % ME];
      end
    end
    if (!w) begin
      expq_id.push_back(id);
      expq_data.push_back(d);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send(input logic w, input logic [IW-1:0] id,
                      input logic [DAW-1:0] addr, input logic [3:0] m,
                      input logic [4*EW-1:0] wd);
    int   guard;
    logic acc;
    guard     = 0;
    req_valid = 1'b1;
    req_write = w;
    req_id    = id;
    req_addr  = addr;
    req_mask  = m;
    req_wdata = wd;
    do begin
      acc = !dram_stall;
      tick(1);
      guard++;
    end while (!acc && guard < 200);
    chk("send_accept", 64'(acc), 64'd1);
    if (acc) model_accept(w, id, addr, m, wd);
    req_valid = 1'b0;
  endtask

  task automatic wait_valid(output int n);
    n = 0;
    while (!res_valid && n < 50) begin
      tick(1);
      n++;
    end
  endtask

  task automatic drain();
    int guard;
    guard = 0;
    while ((expq_id.size() != 0 || busy) && guard < 500) begin
      tick(1);
      guard++;
    end
    chk("drain_pending", 64'(expq_id.size()), 64'd0);
    chk("drain_busy", 64'(busy), 64'd0);
  endtask

  initial begin
    logic [EW-1:0]  a, b, c, d;
    logic [DAW-1:0] x;
    int             n;
    int             r0;

    for (int i = 0; i < ME; i++) mmem[i] = '0;
    rst = 1'b1; req_valid = 1'b0; req_write = 1'b0; req_id = '0;
    req_addr = '0; req_mask = '0; req_wdata = '0; be_stall = 1'b0;
    tick(3);
    chk("rst_res_valid", 64'(res_valid), 64'd0);
    chk("rst_res_id", 64'(res_id), 64'd0);
    chk("rst_rdata", res_rdata, 64'd0);
    chk("rst_dram_stall", 64'(dram_stall), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    rst = 1'b0;
    tick(1);

    // T1: full write, read back, latency from pop
    a = 16'($urandom); b = 16'($urandom); c = 16'($urandom); d = 16'($urandom);
    send(1'b1, 8'h00, 32'h40, 4'b1111, {d, c, b, a});
    send(1'b0, 8'h2A, 32'h40, 4'b1111, 64'd0);
    wait_valid(n);
    chk("t1_latency", 64'(n), 64'(RL));
    drain();
    chk("t1_id", 64'(last_id), 64'h2A);
    chk("t1_rdata", last_rdata, {d, c, b, a});

    // T2: masked write over zeros, masked read
    send(1'b1, 8'h00, 32'h80, 4'b1111, 64'd0);
    send(1'b1, 8'h00, 32'h80, 4'b0101, {16'd4, 16'd3, 16'd2, 16'd1});
    send(1'b0, 8'h11, 32'h80, 4'b0011, 64'd0);
    drain();
    chk("t2_rdata", last_rdata, 64'h0000_0000_0000_0001);

    // T3: backend stall in RESP, FIFO fills, 5th request held
    send(1'b0, 8'h33, 32'h40, 4'b1111, 64'd0);
    wait_valid(n);
    chk("t3_resp_reached", 64'(res_valid), 64'd1);
    be_stall = 1'b1;
    for (int i = 0; i < 4; i++)
      send(1'b0, 8'(8'h40 + i), 32'h80, 4'($urandom), 64'd0);
    chk("t3_full_stall", 64'(dram_stall), 64'd1);
    req_valid = 1'b1; req_write = 1'b0; req_id = 8'h44;
    req_addr = 32'h40; req_mask = 4'b1010;
    for (int i = 0; i < 3; i++) begin
      tick(1);
      chk("t3_still_full", 64'(dram_stall), 64'd1);
      chk("t3_still_resp", 64'(res_valid), 64'd1);
    end
    be_stall = 1'b0;
    send(1'b0, 8'h44, 32'h40, 4'b1010, 64'd0);
    drain();
    chk("t3_last_id", 64'(last_id), 64'h44);

    // T4: write wrapping past the top of the store
    a = 16'($urandom); b = 16'($urandom); c = 16'($urandom); d = 16'($urandom);
    send(1'b1, 8'h00, 32'(ME - 2), 4'b1111, {d, c, b, a});
    send(1'b0, 8'h55, 32'h0, 4'b0011, 64'd0);
    drain();
    chk("t4_rdata", last_rdata, {16'd0, 16'd0, d, c});

    // T5: read-write-read ordering on one element
    x = 32'h200 + 32'($urandom_range(0, 63));
    send(1'b1, 8'h00, x, 4'b0001, 64'd7);
    drain();
    send(1'b0, 8'h61, x, 4'b0001, 64'd0);
    send(1'b1, 8'h00, x, 4'b0001, 64'd9);
    send(1'b0, 8'h62, x, 4'b0001, 64'd0);
    drain();
    chk("t5_last", last_rdata, 64'd9);

    // T6: reset while a read waits; it must never answer
    send(1'b0, 8'h66, 32'h40, 4'b1111, 64'd0);
    tick(2);
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
    expq_id.delete();
    expq_data.delete();
    chk("t6_rst_busy", 64'(busy), 64'd0);
    chk("t6_rst_valid", 64'(res_valid), 64'd0);
    r0 = n_resp;
    send(1'b0, 8'h67, 32'h80, 4'b1111, 64'd0);
    send(1'b0, 8'h68, 32'h40, 4'b1111, 64'd0);
    drain();
    tick(10);
    chk("t6_resp_count", 64'(n_resp - r0), 64'd2);
    chk("t6_last_id", 64'(last_id), 64'h68);
    chk("t6_busy", 64'(busy), 64'd0);

    // Random traffic over a prewritten window, random upper address bits
    for (int i = 0; i < 4; i++)
      send(1'b1, 8'h00, 32'h100 + 32'(4 * i), 4'b1111,
           {32'($urandom), 32'($urandom)});
    for (int i = 0; i < 80; i++) begin
      logic [DAW-1:0] ra;
      ra = ($urandom & 32'hFFFF_F000) | (32'h100 + 32'($urandom_range(0, 12)));
      if ($urandom_range(0, 3) == 0) begin
        be_stall = 1'b1;
        tick($urandom_range(1, 3));
        be_stall = 1'b0;
      end
      send(1'($urandom), 8'($urandom), ra, 4'($urandom),
           {32'($urandom), 32'($urandom)});
    end
    drain();

    chk("final_queue", 64'(expq_id.size()), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
